// File: rtl/hier_rsp_pkg.sv
// -----------------------------------------------------------------------------
// hier_rsp_pkg
// Shared types and helpers for hier_node_responder.
//   state_t   : responder FSM states
//   ERR_ID    : all-ones identifier returned when a child never answers
//               (only used when HIER_RSP_TIMEOUT_EN is defined)
//   pop_digit : extracts the lowest route digit from a path
// -----------------------------------------------------------------------------
package hier_rsp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOCAL = 3'd1,
        ST_FWD   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RSP   = 3'd4
    } state_t;

    // Upper bounds the helpers are sized for; instances slice down to ID_W / DIGIT_W.
    localparam int ID_W_MAX    = 64;
    localparam int DIGIT_W_MAX = 8;

    localparam logic [ID_W_MAX-1:0] ERR_ID = {ID_W_MAX{1'b1}};

    // Returns the lowest digit_w bits of the path (the next hop), zero-extended.
    function automatic logic [DIGIT_W_MAX-1:0] pop_digit(
        input logic [DIGIT_W_MAX-1:0] path_low,
        input int unsigned            digit_w
    );
        logic [DIGIT_W_MAX-1:0] mask;
        mask = (DIGIT_W_MAX'(1'b1) << digit_w) - DIGIT_W_MAX'(1'b1);
        return path_low & mask;
    endfunction

endpackage

// File: rtl/hier_node_responder.sv
// -----------------------------------------------------------------------------
// hier_node_responder
// Enumeration responder/router for one node of a generated hierarchy.
// A request whose depth is zero is answered locally with NODE_ID; otherwise the
// lowest path digit selects a child, the request is forwarded with the path
// shifted down one digit and depth-1, and the child's response is relayed up.
// Instances chain: child-side dn_* ports connect to the up_* ports below.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   up_req_valid/ready/path/depth request from parent
//   up_rsp_valid/ready/id/err     response to parent
//   dn_req_valid/ready            one-hot request handshake per child
//   dn_req_path/depth             forwarded route, shared by all children
//   dn_rsp_valid/ready/id/err     per-child response handshake and payload
//
// Optional build macro: HIER_RSP_TIMEOUT_EN adds parameter TIMEOUT_CYC and a
// watchdog that abandons a child after TIMEOUT_CYC cycles in FWD/WAIT and
// answers err=1, id=all-ones.
// -----------------------------------------------------------------------------
module hier_node_responder
    import hier_rsp_pkg::*;
#(
    parameter int              NUM_CHILDREN = 5,
    parameter int              DIGIT_W      = 3,
    parameter int              MAX_DEPTH    = 10,
    parameter int              ID_W         = 16,
    parameter logic [ID_W-1:0] NODE_ID      = {ID_W{1'b0}}
`ifdef HIER_RSP_TIMEOUT_EN
    ,
    parameter int              TIMEOUT_CYC  = 255
`endif
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              up_req_valid,
    output logic                              up_req_ready,
    input  logic [DIGIT_W*MAX_DEPTH-1:0]      up_req_path,
    input  logic [$clog2(MAX_DEPTH+1)-1:0]    up_req_depth,
    output logic                              up_rsp_valid,
    input  logic                              up_rsp_ready,
    output logic [ID_W-1:0]                   up_rsp_id,
    output logic                              up_rsp_err,
    output logic [NUM_CHILDREN-1:0]           dn_req_valid,
    input  logic [NUM_CHILDREN-1:0]           dn_req_ready,
    output logic [DIGIT_W*MAX_DEPTH-1:0]      dn_req_path,
    output logic [$clog2(MAX_DEPTH+1)-1:0]    dn_req_depth,
    input  logic [NUM_CHILDREN-1:0]           dn_rsp_valid,
    output logic [NUM_CHILDREN-1:0]           dn_rsp_ready,
    input  logic [NUM_CHILDREN*ID_W-1:0]      dn_rsp_id,
    input  logic [NUM_CHILDREN-1:0]           dn_rsp_err
);

    localparam int PATH_W  = DIGIT_W * MAX_DEPTH;
    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
    localparam int SEL_W   = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1;

    state_t                  r_state,    w_state_nxt;
    logic [SEL_W-1:0]        r_sel,      w_sel_nxt;
    logic [PATH_W-1:0]       r_dn_path,  w_dn_path_nxt;
    logic [DEPTH_W-1:0]      r_dn_depth, w_dn_depth_nxt;
    logic [ID_W-1:0]         r_id,       w_id_nxt;
    logic                    r_err,      w_err_nxt;

    logic [DIGIT_W_MAX-1:0]  w_digit;
    logic [NUM_CHILDREN-1:0] w_sel_oh;
    logic [ID_W-1:0]         w_child_id;
    logic                    w_child_err;
    logic                    w_timeout;

    assign w_digit     = pop_digit(DIGIT_W_MAX'(up_req_path), unsigned'(DIGIT_W));
    assign w_sel_oh    = NUM_CHILDREN'(1'b1) << r_sel;
    assign w_child_id  = dn_rsp_id[r_sel*ID_W +: ID_W];
    assign w_child_err = dn_rsp_err[r_sel];

`ifdef HIER_RSP_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] r_to_cnt;

    // Watchdog: counts cycles spent in FWD/WAIT; zero whenever the FSM is elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= {TO_W{1'b0}};
        end else if ((w_state_nxt == ST_FWD) || (w_state_nxt == ST_WAIT)) begin
            r_to_cnt <= r_to_cnt + TO_W'(1'b1);
        end else begin
            r_to_cnt <= {TO_W{1'b0}};
        end
    end

    assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYC));
`else
    assign w_timeout = 1'b0;
`endif

    // FSM and response/forwarding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_sel      <= {SEL_W{1'b0}};
            r_dn_path  <= {PATH_W{1'b0}};
            r_dn_depth <= {DEPTH_W{1'b0}};
            r_id       <= {ID_W{1'b0}};
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_dn_path  <= w_dn_path_nxt;
            r_dn_depth <= w_dn_depth_nxt;
            r_id       <= w_id_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // Next-state and next-register logic; everything holds unless a branch updates it.
    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_dn_path_nxt  = r_dn_path;
        w_dn_depth_nxt = r_dn_depth;
        w_id_nxt       = r_id;
        w_err_nxt      = r_err;

        case (r_state)
            ST_IDLE: begin
                if (up_req_valid) begin
                    // The forwarded path/depth are precomputed here so the
                    // dn_* payload comes straight from registers.
                    w_dn_path_nxt = up_req_path >> DIGIT_W;
                    if (up_req_depth == {DEPTH_W{1'b0}}) begin
                        w_dn_depth_nxt = {DEPTH_W{1'b0}};
                        w_state_nxt    = ST_LOCAL;
                    end else if (up_req_depth > DEPTH_W'(MAX_DEPTH)) begin
                        w_dn_depth_nxt = up_req_depth - DEPTH_W'(1'b1);
                        w_id_nxt       = {ID_W{1'b0}};
                        w_err_nxt      = 1'b1;
                        w_state_nxt    = ST_RSP;
                    end else if (w_digit < DIGIT_W_MAX'(NUM_CHILDREN)) begin
                        w_dn_depth_nxt = up_req_depth - DEPTH_W'(1'b1);
                        w_sel_nxt      = w_digit[SEL_W-1:0];
                        w_state_nxt    = ST_FWD;
                    end else begin
                        w_dn_depth_nxt = up_req_depth - DEPTH_W'(1'b1);
                        w_id_nxt       = {ID_W{1'b0}};
                        w_err_nxt      = 1'b1;
                        w_state_nxt    = ST_RSP;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_LOCAL: begin
                w_id_nxt    = NODE_ID;
                w_err_nxt   = 1'b0;
                w_state_nxt = ST_RSP;
            end

            ST_FWD: begin
                // A real handshake wins over a watchdog expiry in the same cycle.
                if (dn_req_ready[r_sel]) begin
                    w_state_nxt = ST_WAIT;
                end else if (w_timeout) begin
                    w_id_nxt    = ERR_ID[ID_W-1:0];
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_RSP;
                end else begin
                    w_state_nxt = ST_FWD;
                end
            end

            ST_WAIT: begin
                if (dn_rsp_valid[r_sel]) begin
                    w_id_nxt    = w_child_id;
                    w_err_nxt   = w_child_err;
                    w_state_nxt = ST_RSP;
                end else if (w_timeout) begin
                    w_id_nxt    = ERR_ID[ID_W-1:0];
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_RSP;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end

            ST_RSP: begin
                if (up_rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RSP;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from registered state only, so they are glitch-free
    // and stable for the whole cycle.
    assign up_req_ready = (r_state == ST_IDLE);
    assign up_rsp_valid = (r_state == ST_RSP);
    assign up_rsp_id    = r_id;
    assign up_rsp_err   = r_err;
    assign dn_req_valid = (r_state == ST_FWD)  ? w_sel_oh : {NUM_CHILDREN{1'b0}};
    assign dn_rsp_ready = (r_state == ST_WAIT) ? w_sel_oh : {NUM_CHILDREN{1'b0}};
    assign dn_req_path  = r_dn_path;
    assign dn_req_depth = r_dn_depth;

endmodule

// File: tb/tb_hier_node_responder.sv
`timescale 1ns/1ps
module tb_hier_node_responder;

    localparam int NC  = 5;
    localparam int IW  = 16;
    localparam int PW  = 30;
    localparam int DPW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // root node
    logic            up_req_valid, up_req_ready, up_rsp_valid, up_rsp_ready, up_rsp_err;
    logic [PW-1:0]   up_req_path;
    logic [DPW-1:0]  up_req_depth;
    logic [IW-1:0]   up_rsp_id;
    logic [NC-1:0]   root_dn_req_valid, root_dn_req_ready, root_dn_rsp_valid;
    logic [NC-1:0]   root_dn_rsp_ready, root_dn_rsp_err;
    logic [PW-1:0]   root_dn_req_path;
    logic [DPW-1:0]  root_dn_req_depth;
    logic [NC*IW-1:0] root_dn_rsp_id;

    // mid node (child 2 of root) and leaf node (child 4 of mid)
    logic            mid_up_req_ready, mid_up_rsp_valid, mid_up_rsp_err;
    logic [IW-1:0]   mid_up_rsp_id;
    logic [NC-1:0]   mid_dn_req_valid, mid_dn_rsp_ready;
    logic [PW-1:0]   mid_dn_req_path;
    logic [DPW-1:0]  mid_dn_req_depth;
    logic            leaf_up_req_ready, leaf_up_rsp_valid, leaf_up_rsp_err;
    logic [IW-1:0]   leaf_up_rsp_id;
    logic [NC-1:0]   leaf_dn_req_valid, leaf_dn_rsp_ready;
    logic [PW-1:0]   leaf_dn_req_path;
    logic [DPW-1:0]  leaf_dn_req_depth;

    // behavioural children 0,1,3,4 of root
    logic [NC-1:0]   m_pend;
    logic            m_mute;

    always_comb begin
        root_dn_req_ready    = 5'b11011;
        root_dn_req_ready[2] = mid_up_req_ready;
        root_dn_rsp_valid    = m_pend & {NC{~m_mute}};
        root_dn_rsp_valid[2] = mid_up_rsp_valid;
        root_dn_rsp_err      = 5'b00000;
        root_dn_rsp_err[2]   = mid_up_rsp_err;
        root_dn_rsp_id       = {16'h4444, 16'h1234, 16'h0000, 16'h1111, 16'h1000};
        root_dn_rsp_id[2*IW +: IW] = mid_up_rsp_id;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= 5'b00000;
        end else begin
            for (int i = 0; i < NC; i++) begin
                if (i != 2) begin
                    if (root_dn_req_valid[i] && root_dn_req_ready[i]) m_pend[i] <= 1'b1;
                    else if (root_dn_rsp_valid[i] && root_dn_rsp_ready[i]) m_pend[i] <= 1'b0;
                end
            end
        end
    end

    hier_node_responder #(.NODE_ID(16'h00A5)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .up_req_valid(up_req_valid), .up_req_ready(up_req_ready),
        .up_req_path(up_req_path), .up_req_depth(up_req_depth),
        .up_rsp_valid(up_rsp_valid), .up_rsp_ready(up_rsp_ready),
        .up_rsp_id(up_rsp_id), .up_rsp_err(up_rsp_err),
        .dn_req_valid(root_dn_req_valid), .dn_req_ready(root_dn_req_ready),
        .dn_req_path(root_dn_req_path), .dn_req_depth(root_dn_req_depth),
        .dn_rsp_valid(root_dn_rsp_valid), .dn_rsp_ready(root_dn_rsp_ready),
        .dn_rsp_id(root_dn_rsp_id), .dn_rsp_err(root_dn_rsp_err)
    );

    hier_node_responder #(.NODE_ID(16'h0200)) u_mid (
        .clk(clk), .rst_n(rst_n),
        .up_req_valid(root_dn_req_valid[2]), .up_req_ready(mid_up_req_ready),
        .up_req_path(root_dn_req_path), .up_req_depth(root_dn_req_depth),
        .up_rsp_valid(mid_up_rsp_valid), .up_rsp_ready(root_dn_rsp_ready[2]),
        .up_rsp_id(mid_up_rsp_id), .up_rsp_err(mid_up_rsp_err),
        .dn_req_valid(mid_dn_req_valid), .dn_req_ready({leaf_up_req_ready, 4'b0000}),
        .dn_req_path(mid_dn_req_path), .dn_req_depth(mid_dn_req_depth),
        .dn_rsp_valid({leaf_up_rsp_valid, 4'b0000}), .dn_rsp_ready(mid_dn_rsp_ready),
        .dn_rsp_id({leaf_up_rsp_id, 64'h0}), .dn_rsp_err({leaf_up_rsp_err, 4'b0000})
    );

    hier_node_responder #(.NODE_ID(16'h0204)) u_leaf (
        .clk(clk), .rst_n(rst_n),
        .up_req_valid(mid_dn_req_valid[4]), .up_req_ready(leaf_up_req_ready),
        .up_req_path(mid_dn_req_path), .up_req_depth(mid_dn_req_depth),
        .up_rsp_valid(leaf_up_rsp_valid), .up_rsp_ready(mid_dn_rsp_ready[4]),
        .up_rsp_id(leaf_up_rsp_id), .up_rsp_err(leaf_up_rsp_err),
        .dn_req_valid(leaf_dn_req_valid), .dn_req_ready(5'b00000),
        .dn_req_path(leaf_dn_req_path), .dn_req_depth(leaf_dn_req_depth),
        .dn_rsp_valid(5'b00000), .dn_rsp_ready(leaf_dn_rsp_ready),
        .dn_rsp_id(80'h0), .dn_rsp_err(5'b00000)
    );

    int              total;
    int              bad;
    logic [IW:0]     exp_q[$];   // {id, err}
    logic [NC-1:0]   seen_v;
    logic [DPW-1:0]  seen_depth;
    logic [PW-1:0]   seen_path;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compares every up-side response handshake against the queue.
    task automatic monitor();
        logic [IW:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && up_rsp_valid && up_rsp_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected: actual id=%0h err=%0b required no response", up_rsp_id, up_rsp_err);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", 64'(up_rsp_id), 64'(e[IW:1]));
                    chk("rsp_err", 64'(up_rsp_err), 64'(e[0]));
                end
            end
        end
    endtask

    // Records which root child requests were raised and with what payload.
    task automatic capture();
        forever begin
            @(negedge clk);
            if (root_dn_req_valid != 5'b00000) begin
                seen_v     = seen_v | root_dn_req_valid;
                seen_depth = root_dn_req_depth;
                seen_path  = root_dn_req_path;
            end
        end
    endtask

    task automatic send_req(input logic [PW-1:0] p, input logic [DPW-1:0] d);
        int n;
        n = 0;
        up_req_valid = 1'b1;
        up_req_path  = p;
        up_req_depth = d;
        @(negedge clk);
        while (!up_req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("req_accept", 64'(up_req_ready), 64'd1);
        @(posedge clk);
        #1;
        up_req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   cnt;
        logic flag;
        total = 0;
        bad = 0;
        up_req_valid = 1'b0;
        up_req_path  = '0;
        up_req_depth = '0;
        up_rsp_ready = 1'b1;
        m_mute = 1'b0;
        seen_v = '0;
        seen_depth = '0;
        seen_path = '0;
        fork
            monitor();
            capture();
        join_none

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(up_req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(up_rsp_valid), 64'd0);
        chk("rst_dn_req_valid", 64'(root_dn_req_valid), 64'd0);
        chk("rst_dn_rsp_ready", 64'(root_dn_rsp_ready), 64'd0);
        chk("rst_rsp_id", 64'(up_rsp_id), 64'd0);
        chk("rst_rsp_err", 64'(up_rsp_err), 64'd0);
        chk("rst_dn_path", 64'(root_dn_req_path), 64'd0);
        chk("rst_dn_depth", 64'(root_dn_req_depth), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // local answer and its latency
        exp_q.push_back({16'h00A5, 1'b0});
        send_req(30'd0, 4'd0);
        cnt = 1;
        while (!up_rsp_valid && cnt < 50) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("local_latency", 64'(cnt), 64'd2);
        drain();

        // child 3, with a second digit to check the shift
        seen_v = '0;
        exp_q.push_back({16'h1234, 1'b0});
        send_req(30'd3 | (30'd5 << 3), 4'd1);
        drain();
        chk("c3_onehot", 64'(seen_v), 64'b01000);
        chk("c3_dn_depth", 64'(seen_depth), 64'd0);
        chk("c3_dn_path", 64'(seen_path), 64'd5);

        // lowest and highest valid child
        seen_v = '0;
        exp_q.push_back({16'h1000, 1'b0});
        send_req(30'd0, 4'd1);
        drain();
        chk("c0_onehot", 64'(seen_v), 64'b00001);
        seen_v = '0;
        exp_q.push_back({16'h4444, 1'b0});
        send_req(30'd4, 4'd1);
        drain();
        chk("c4_onehot", 64'(seen_v), 64'b10000);

        // route errors: digit 6, digit 5 (== NUM_CHILDREN), depth 11 (> MAX_DEPTH)
        seen_v = '0;
        exp_q.push_back({16'h0000, 1'b1});
        send_req(30'd6, 4'd1);
        drain();
        exp_q.push_back({16'h0000, 1'b1});
        send_req(30'd5, 4'd1);
        drain();
        exp_q.push_back({16'h0000, 1'b1});
        send_req(30'd0, 4'd11);
        drain();
        chk("err_no_fwd", 64'(seen_v), 64'd0);

        // mid node answers locally
        exp_q.push_back({16'h0200, 1'b0});
        send_req(30'd2, 4'd1);
        drain();

        // two-level route {2,4}: leaf answers, root stays busy throughout
        seen_v = '0;
        flag = 1'b0;
        exp_q.push_back({16'h0204, 1'b0});
        send_req(30'd2 | (30'd4 << 3), 4'd2);
        cnt = 0;
        while (!up_rsp_valid && cnt < 100) begin
            if (up_req_ready) flag = 1'b1;
            @(posedge clk);
            #1;
            cnt++;
        end
        if (up_req_ready) flag = 1'b1;
        chk("chain_busy_ready", 64'(flag), 64'd0);
        drain();
        chk("chain_onehot", 64'(seen_v), 64'b00100);
        chk("chain_dn_depth", 64'(seen_depth), 64'd1);
        chk("chain_dn_path", 64'(seen_path), 64'd4);

        // response back-pressure with a second request waiting
        up_rsp_ready = 1'b0;
        exp_q.push_back({16'h00A5, 1'b0});
        send_req(30'd0, 4'd0);
        cnt = 0;
        while (!up_rsp_valid && cnt < 50) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        exp_q.push_back({16'h00A5, 1'b0});
        up_req_valid = 1'b1;
        up_req_path  = 30'd0;
        up_req_depth = 4'd0;
        flag = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (up_rsp_valid !== 1'b1 || up_rsp_id !== 16'h00A5 || up_rsp_err !== 1'b0 ||
                up_req_ready !== 1'b0) flag = 1'b0;
        end
        chk("stall_stable", 64'(flag), 64'd1);
        up_rsp_ready = 1'b1;
        cnt = 0;
        @(negedge clk);
        while (!up_req_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        @(posedge clk);
        #1;
        up_req_valid = 1'b0;
        drain();

        // reset while waiting on a silent child
        m_mute = 1'b1;
        send_req(30'd1, 4'd1);
        cnt = 0;
        while (root_dn_rsp_ready != 5'b00010 && cnt < 50) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("wait_reached", 64'(root_dn_rsp_ready), 64'b00010);
        chk("wait_req_ready", 64'(up_req_ready), 64'd0);
        rst_n = 1'b0;
        #2;
        chk("midrst_req_ready", 64'(up_req_ready), 64'd1);
        chk("midrst_dn_rsp_ready", 64'(root_dn_rsp_ready), 64'd0);
        chk("midrst_rsp_valid", 64'(up_rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_mute = 1'b0;
        @(posedge clk);
        #1;

        // recovery
        exp_q.push_back({16'h00A5, 1'b0});
        send_req(30'd0, 4'd0);
        drain();

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hier_node_responder.md
Name: hier_node_responder

Overview:
- Responder/router placed at every node of a generated instance hierarchy. Each node instantiates up to NUM_CHILDREN children, indexed 0..4.
- Accepts an enumeration request from its parent. If the request targets this node, it answers with this node's NODE_ID. Otherwise it pops one path digit, forwards the request to the selected child and relays that child's response upward.
- Composes recursively: the child-side ports of one instance connect to the parent-side ports of the instances below it.

Parameters:
- NUM_CHILDREN, 5, number of child ports (1..8)
- DIGIT_W, 3, bits per path digit
- MAX_DEPTH, 10, maximum hops a path can encode
- ID_W, 16, width of the node identifier
- NODE_ID, 0, identifier this node returns

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- up_req_valid  in  1  request from parent valid
- up_req_ready  out  1  responder can accept request
- up_req_path  in  DIGIT_W*MAX_DEPTH  route, lowest digit first
- up_req_depth  in  $clog2(MAX_DEPTH+1)  hops remaining
- up_rsp_valid  out  1  response to parent valid
- up_rsp_ready  in  1  parent accepts response
- up_rsp_id  out  ID_W  returned identifier
- up_rsp_err  out  1  route error
- dn_req_valid  out  NUM_CHILDREN  one-hot request to child
- dn_req_ready  in  NUM_CHILDREN  per-child ready
- dn_req_path  out  DIGIT_W*MAX_DEPTH  shifted path, shared by all children
- dn_req_depth  out  $clog2(MAX_DEPTH+1)  depth-1, shared by all children
- dn_rsp_valid  in  NUM_CHILDREN  per-child response valid
- dn_rsp_ready  out  NUM_CHILDREN  one-hot response ready
- dn_rsp_id  in  NUM_CHILDREN*ID_W  packed child ids
- dn_rsp_err  in  NUM_CHILDREN  child error flags

Behaviour:
- Clocking and reset
  - Single clock domain, clk. Reset is asynchronous, active-low, on rst_n.
  - Reset state: IDLE, all valids 0, up_req_ready 1, up_rsp_id 0, up_rsp_err 0, dn_req_path 0, dn_req_depth 0, sel 0.
- Handshakes
  - A transfer occurs on any cycle where valid and ready are both 1.
  - Once valid is raised, it and its payload are held until the transfer.
  - Only one request is in flight per node. up_req_ready is 1 only in IDLE.
- FSM states: IDLE, LOCAL, FWD, WAIT, RSP.
- IDLE, on up_req handshake: latch the path and depth.
  - depth==0: go to LOCAL.
  - depth!=0 and the lowest digit is below NUM_CHILDREN: set sel to that digit and go to FWD.
  - depth!=0 and the lowest digit is NUM_CHILDREN or above: set err=1, id=0 and go to RSP.
  - depth greater than MAX_DEPTH is treated as a route error (err=1, id=0, go to RSP).
- LOCAL: one cycle. Loads id=NODE_ID, err=0, then goes to RSP.
  - Latency from request handshake to up_rsp_valid is 2 cycles.
- FWD
  - Drives dn_req_valid[sel]=1.
  - dn_req_path is the latched path shifted right by DIGIT_W, zero-filled at the top.
  - dn_req_depth is the latched depth minus 1.
  - On dn_req_ready[sel], go to WAIT. Other children's ready inputs are ignored.
- WAIT
  - Drives dn_rsp_ready[sel]=1.
  - On dn_rsp_valid[sel], captures the child's id and err, then goes to RSP.
  - dn_rsp_valid from unselected children is ignored and never acknowledged.
- RSP: up_rsp_valid=1 with the registered id and err. On up_rsp_ready, go to IDLE.
- Up-side accept and respond: the response is registered, so a new request can be accepted on the cycle after the response handshake.
- Back-to-back requests: the FSM returns to IDLE after every response, giving a throughput of one request per (latency+1) cycles.
- Reset mid-operation forces IDLE immediately. An outstanding child transaction is abandoned; children are reset by the same rst_n.

Optional Feature:
- Macro: HIER_RSP_TIMEOUT_EN.
- When defined, parameter TIMEOUT_CYC (default 255) is added.
  - A counter runs while the FSM is in FWD or WAIT and clears whenever the FSM leaves those states.
  - When the count reaches TIMEOUT_CYC, the FSM goes to RSP with err=1, id={ID_W{1'b1}}, and deasserts all dn_* valid and ready outputs.
- When not defined, the FSM waits indefinitely in FWD and WAIT, and no counter logic is present.

Decomposition:
- Package hier_rsp_pkg holds:
  - state enum typedef
  - ERR_ID constant
  - function that pops a digit from the path
- No sub-module is needed. The one-hot select is derived inline from sel.

Test Plan:
- depth=0, NODE_ID=16'h00A5 -> up_rsp_valid 2 cycles after request handshake, id=16'h00A5, err=0.
- path digit 3, depth=1; child 3 model returns id 16'h1234 -> only dn_req_valid[3] is asserted, dn_req_depth=0, up_rsp_id=16'h1234, err=0.
- path digit 6, depth=1, NUM_CHILDREN=5 -> no dn_req_valid asserted, up_rsp_err=1, id=0.
- Two-level chained instances, path digits {2,4}, depth=2 -> the leaf at index 4 under child 2 answers with its NODE_ID; up_req_ready stays 0 throughout.
- up_rsp_ready held 0 for 5 cycles -> id and err are stable and no new request is accepted; rst_n pulse while in WAIT -> IDLE, up_req_ready=1.
- With HIER_RSP_TIMEOUT_EN and TIMEOUT_CYC=8, child never responds -> err=1, id=16'hFFFF after 8 cycles in FWD/WAIT.
